// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// core load/store path (side 0) and the debug/loader port (side 1).
// Round-robin arbitration, bounded locked bursts, and routing of the
// one-cycle-latency read data back to the side that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic                clk,
  input  logic                reset,
  // core requester
  input  logic                c_req,
  input  logic                c_lock,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_be,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  // debug/loader requester
  input  logic                d_req,
  input  logic                d_lock,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic {SIDE_CORE = 1'b0, SIDE_DBG = 1'b1} side_e;

  side_e             last_owner, last_owner_nxt;
  logic              locked,     locked_nxt;
  logic [CNT_W-1:0]  lock_cnt,   lock_cnt_nxt;
  logic              rd_pend,    rd_pend_nxt;
  side_e             rd_tag,     rd_tag_nxt;

  logic              gnt_vld;
  side_e             gnt_side;
  logic              own_req, oth_req;
  logic              sel_lock, sel_we;

  // State register; last_owner resets to debug so the core wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= SIDE_DBG;
      locked     <= 1'b0;
      lock_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_tag     <= SIDE_CORE;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      last_owner <= last_owner_nxt;
      locked     <= locked_nxt;
      lock_cnt   <= lock_cnt_nxt;
      rd_pend    <= rd_pend_nxt;
      rd_tag     <= rd_tag_nxt;
    end
  end

  // Grant decision: honour a live lock up to MAX_LOCK beats, else round-robin.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    gnt_vld  = 1'b0;
    gnt_side = SIDE_CORE;
    own_req  = (last_owner == SIDE_DBG) ? d_req : c_req;
    oth_req  = (last_owner == SIDE_DBG) ? c_req : d_req;
    if (!reset) begin
      gnt_vld = 1'b0;
    end else if (locked && own_req) begin
      gnt_vld = 1'b1;
      if (lock_cnt < LOCK_MAX || !oth_req) gnt_side = last_owner;
      else                                 gnt_side = side_e'(~last_owner);
    end else if (c_req && d_req) begin
      gnt_vld  = 1'b1;
      gnt_side = side_e'(~last_owner);
    end else if (c_req) begin
      gnt_vld  = 1'b1;
      gnt_side = SIDE_CORE;
    end else if (d_req) begin
      gnt_vld  = 1'b1;
      gnt_side = SIDE_DBG;
    end
  end

  // Next-state: ownership, lock run length and the read-return tag.
  always_comb begin
    sel_lock       = (gnt_side == SIDE_DBG) ? d_lock : c_lock;
    sel_we         = (gnt_side == SIDE_DBG) ? d_we   : c_we;
    last_owner_nxt = last_owner;
    locked_nxt     = locked;
    lock_cnt_nxt   = lock_cnt;
    rd_pend_nxt    = 1'b0;
    rd_tag_nxt     = rd_tag;
    if (gnt_vld) begin
      last_owner_nxt = gnt_side;
      if (sel_lock) begin
        locked_nxt = 1'b1;
        if (locked && last_owner == gnt_side)
          lock_cnt_nxt = (lock_cnt >= LOCK_MAX) ? LOCK_MAX : lock_cnt + 1'b1;
        else
          lock_cnt_nxt = CNT_W'(1);
      end else begin
        locked_nxt   = 1'b0;
        lock_cnt_nxt = '0;
      end
      if (!sel_we) begin
        rd_pend_nxt = 1'b1;
        rd_tag_nxt  = gnt_side;
      end
    end else if (locked) begin
      // Owner went idle with nobody granted: the lock is dropped.
      locked_nxt   = 1'b0;
      lock_cnt_nxt = '0;
    end
  end

  // Outputs: grant strobes, memory mux (zero when idle), read-data steering.
  always_comb begin
    c_gnt     = gnt_vld && (gnt_side == SIDE_CORE);
    d_gnt     = gnt_vld && (gnt_side == SIDE_DBG);
    mem_en    = gnt_vld;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_be    = c_be;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
    c_rvalid = rd_pend && (rd_tag == SIDE_CORE);
    d_rvalid = rd_pend && (rd_tag == SIDE_DBG);
    c_rdata  = c_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of per-cycle request patterns
// with hand-computed grant/rvalid expectations, plus short hand sequences
// for the write path and reset during an in-flight read.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 8;
  localparam logic [31:0] CORE_RD = 32'hA000_0008;  // word at 0x20
  localparam logic [31:0] DBG_RD  = 32'hDEAD_BEEF;  // word at 0x40

  logic              clk, reset;
  logic              c_req, c_lock, c_we, c_gnt, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic [3:0]        c_be;
  logic              d_req, d_lock, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [3:0]        d_be;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [3:0]        mem_be;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_lock(c_lock), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_be(c_be), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .c_rdata(c_rdata),
    .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous memory model, 256 words, one-cycle read latency.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[16] = DBG_RD;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       c_req, c_lock, d_req, d_lock;
    logic [3:0] flags;   // {c_gnt, d_gnt, c_rvalid, d_rvalid}
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic cr, input logic cl, input logic dr, input logic dl,
                     input logic [3:0] f, input int reps = 1);
    vec_t v;
    v.c_req = cr; v.c_lock = cl; v.d_req = dr; v.d_lock = dl; v.flags = f;
    for (int r = 0; r < reps; r++) tbl.push_back(v);
  endtask

  initial begin
    // Contention: strict alternation starting with the core.
    add(1,0,1,0, 4'b1000);
    add(1,0,1,0, 4'b0110);
    add(1,0,1,0, 4'b1001);
    add(1,0,1,0, 4'b0110);
    add(1,0,1,0, 4'b1001);
    add(1,0,1,0, 4'b0110);
    add(0,0,0,0, 4'b0001);
    add(0,0,0,0, 4'b0000);
    // Single debug read.
    add(0,0,1,0, 4'b0100);
    add(0,0,0,0, 4'b0001);
    // Debug locked burst: 8 grants, then forced release to the core.
    add(0,0,1,1, 4'b0100);
    add(1,0,1,1, 4'b0101, 7);
    add(1,0,1,1, 4'b1001);
    add(1,0,1,1, 4'b0110);
    add(0,0,0,0, 4'b0001);
    add(0,0,0,0, 4'b0000);
    // Core locks 2 beats then abandons; alternation resumes immediately.
    add(1,1,0,0, 4'b1000);
    add(1,1,1,0, 4'b1010);
    add(0,0,1,0, 4'b0110);
    add(1,0,1,0, 4'b1001);
    add(1,0,1,0, 4'b0110);
    add(0,0,0,0, 4'b0001);
    // Uncontended lock past MAX_LOCK saturates; core then wins at once.
    add(0,0,1,1, 4'b0100);
    add(0,0,1,1, 4'b0101, 9);
    add(1,0,1,1, 4'b1001);
    add(0,0,0,0, 4'b0010);
    add(0,0,0,0, 4'b0000);

    reset = 1'b0;
    c_req = 1'b1; c_lock = 1'b0; c_we = 1'b0; c_addr = 32'h20; c_wdata = 32'h0; c_be = 4'hF;
    d_req = 1'b1; d_lock = 1'b0; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h0; d_be = 4'hF;

    // Reset held with both requesting: everything quiet.
    @(negedge clk);
    @(negedge clk); #2;
    check("rst c_gnt",    32'(c_gnt),    32'd0);
    check("rst d_gnt",    32'(d_gnt),    32'd0);
    check("rst mem_en",   32'(mem_en),   32'd0);
    check("rst c_rvalid", 32'(c_rvalid), 32'd0);
    check("rst d_rvalid", 32'(d_rvalid), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    foreach (tbl[i]) begin
      c_req = tbl[i].c_req; c_lock = tbl[i].c_lock;
      d_req = tbl[i].d_req; d_lock = tbl[i].d_lock;
      #2;
      check($sformatf("vec%0d flags", i), 32'({c_gnt, d_gnt, c_rvalid, d_rvalid}),
            32'(tbl[i].flags));
      check($sformatf("vec%0d c_rdata", i), c_rdata, tbl[i].flags[1] ? CORE_RD : 32'h0);
      check($sformatf("vec%0d d_rdata", i), d_rdata, tbl[i].flags[0] ? DBG_RD : 32'h0);
      if (mem_en)
        check($sformatf("vec%0d mem_addr", i), mem_addr, c_gnt ? 32'h20 : 32'h40);
      @(negedge clk);
    end

    // Core write 0x12345678 to 0x10 with full byte enables.
    c_req = 1'b1; c_lock = 1'b0; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'h1234_5678;
    d_req = 1'b0; d_lock = 1'b0;
    #2;
    check("wr c_gnt",     32'(c_gnt),  32'd1);
    check("wr mem_we",    32'(mem_we), 32'd1);
    check("wr mem_addr",  mem_addr,    32'h10);
    check("wr mem_wdata", mem_wdata,   32'h1234_5678);
    check("wr mem_be",    32'(mem_be), 32'hF);
    @(negedge clk);
    c_req = 1'b0;
    #2;
    check("wr no rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
    check("idle mem_en",  32'(mem_en), 32'd0);
    check("idle mem_addr", mem_addr,   32'h0);
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0;
    #2;
    check("rdback c_gnt", 32'(c_gnt), 32'd1);
    @(negedge clk);
    c_req = 1'b0;
    #2;
    check("rdback c_rvalid", 32'(c_rvalid), 32'd1);
    check("rdback c_rdata",  c_rdata,       32'h1234_5678);
    check("rdback d_rvalid", 32'(d_rvalid), 32'd0);

    // Reset asserted between a read grant and its return edge.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0;
    #2;
    check("rstrd d_gnt", 32'(d_gnt), 32'd1);
    #1 reset = 1'b0;
    @(negedge clk); #2;
    check("rstrd rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
    check("rstrd d_gnt held", 32'(d_gnt), 32'd0);
    check("rstrd mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    reset = 1'b1; c_req = 1'b1; c_addr = 32'h20;
    #2;
    check("post rst gnt", 32'({c_gnt, d_gnt}), 32'b10);
    @(negedge clk);
    c_req = 1'b0; d_req = 1'b0;
    #2;
    check("post rst c_rvalid", 32'(c_rvalid), 32'd1);
    check("post rst c_rdata",  c_rdata,       CORE_RD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
